// File: rtl/uart_frame_ctrl_if.sv
// Command-side bundle for uart_frame_ctrl: UART byte stream in, framed command
// handshake and payload read port out.
interface uart_frame_ctrl_if;
  logic       i_RX_DV;
  logic [7:0] i_RX_Byte;
  logic       o_CMD_Valid;
  logic       i_CMD_Ready;
  logic [7:0] o_CMD_Id;
  logic [7:0] o_CMD_Len;
  logic [7:0] i_Pay_Rd_Addr;
  logic [7:0] o_Pay_Rd_Data;
  logic       o_Err_Chk;
  logic       o_Err_Len;
  logic       o_Err_Timeout;
  logic       o_Drop;
  logic       o_Busy;

  // Frame controller side
  modport slave (
    input  i_RX_DV, i_RX_Byte, i_CMD_Ready, i_Pay_Rd_Addr,
    output o_CMD_Valid, o_CMD_Id, o_CMD_Len, o_Pay_Rd_Data,
    output o_Err_Chk, o_Err_Len, o_Err_Timeout, o_Drop, o_Busy
  );

  // UART receiver / command decoder side
  modport master (
    output i_RX_DV, i_RX_Byte, i_CMD_Ready, i_Pay_Rd_Addr,
    input  o_CMD_Valid, o_CMD_Id, o_CMD_Len, o_Pay_Rd_Data,
    input  o_Err_Chk, o_Err_Len, o_Err_Timeout, o_Drop, o_Busy
  );
endinterface

// File: rtl/uart_frame_ctrl.sv
// UART frame controller: hunts for SYNC, captures ID/LEN/payload/CHK, validates
// the 8-bit additive checksum and holds good frames for a valid/ready consumer.
//
// state   | meaning
// --------+----------------------------------------------------------
// HUNT    | idle, waiting for SYNC_BYTE
// GET_ID  | next byte is the frame ID
// GET_LEN | next byte is the payload length
// GET_PAY | collecting payload bytes into the buffer
// GET_CHK | next byte is the checksum
// HOLD    | good frame presented, waiting for i_CMD_Ready
module uart_frame_ctrl #(
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 8680
) (
  input logic              clk,
  input logic              rst,
  uart_frame_ctrl_if.slave bus
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  // Inter-byte timer is a down-counter: reload value means "just cleared".
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {HUNT, GET_ID, GET_LEN, GET_PAY, GET_CHK, HOLD} state_t;

  state_t        state_q, state_d;
  logic [7:0]    id_q, id_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    idx_q, idx_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          err_chk_q, err_chk_d;
  logic          err_len_q, err_len_d;
  logic          err_to_q, err_to_d;
  logic          drop_q, drop_d;
  logic          pay_we;
  logic          tmo;
  logic          in_frame;
  logic [7:0]    pay_rd_data;
  logic [7:0]    buf_q [MAX_LEN];

  wire       dv = bus.i_RX_DV;
  wire [7:0] rx = bus.i_RX_Byte;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    len_d     = len_q;
    sum_d     = sum_q;
    idx_d     = idx_q;
    err_chk_d = 1'b0;
    err_len_d = 1'b0;
    err_to_d  = 1'b0;
    drop_d    = 1'b0;
    pay_we    = 1'b0;

    in_frame = (state_q == GET_ID) || (state_q == GET_LEN) ||
               (state_q == GET_PAY) || (state_q == GET_CHK);
    // A byte on the terminal-count cycle takes priority over the timeout.
    tmo = in_frame && !dv && (tmr_q == '0);

    case (state_q)
      HUNT: begin
        if (dv && rx == SYNC_BYTE) state_d = GET_ID;
      end
      GET_ID: begin
        if (dv) begin
          id_d    = rx;
          sum_d   = rx;
          state_d = GET_LEN;
        end
      end
      GET_LEN: begin
        if (dv) begin
          len_d = rx;
          sum_d = sum_q + rx;
          idx_d = 8'd0;
          if (rx > 8'(MAX_LEN)) begin
            err_len_d = 1'b1;
            state_d   = HUNT;
          end else if (rx == 8'd0) begin
            state_d = GET_CHK;
          end else begin
            state_d = GET_PAY;
          end
        end
      end
      GET_PAY: begin
        if (dv) begin
          pay_we = 1'b1;
          sum_d  = sum_q + rx;
          idx_d  = idx_q + 8'd1;
          if (idx_q == len_q - 8'd1) state_d = GET_CHK;
        end
      end
      GET_CHK: begin
        if (dv) begin
          if (rx == sum_q) begin
            state_d = HOLD;
          end else begin
            err_chk_d = 1'b1;
            state_d   = HUNT;
          end
        end
      end
      HOLD: begin
        if (dv) drop_d = 1'b1;
        if (valid_q && bus.i_CMD_Ready) state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase

    if (tmo) begin
      err_to_d = 1'b1;
      state_d  = HUNT;
    end

    // Any byte or state change reloads; otherwise count down while in a frame.
    if (in_frame && !dv && !tmo) tmr_d = tmr_q - TW'(1);
    else                         tmr_d = TMR_LOAD;

    valid_d = (state_d == HOLD);
    busy_d  = (state_d != HUNT);
  end

  // FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HUNT;
      id_q      <= 8'd0;
      len_q     <= 8'd0;
      sum_q     <= 8'd0;
      idx_q     <= 8'd0;
      tmr_q     <= TMR_LOAD;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_chk_q <= 1'b0;
      err_len_q <= 1'b0;
      err_to_q  <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      idx_q     <= idx_d;
      tmr_q     <= tmr_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      err_chk_q <= err_chk_d;
      err_len_q <= err_len_d;
      err_to_q  <= err_to_d;
      drop_q    <= drop_d;
    end
  end

  // Payload buffer; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (pay_we && idx_q < 8'(MAX_LEN)) buf_q[idx_q[AW-1:0]] <= rx;
  end

  // Combinational payload read port
  always_comb begin
    pay_rd_data = 8'h00;
    if (bus.i_Pay_Rd_Addr < 8'(MAX_LEN)) pay_rd_data = buf_q[bus.i_Pay_Rd_Addr[AW-1:0]];
  end

  assign bus.o_CMD_Valid   = valid_q;
  assign bus.o_CMD_Id      = id_q;
  assign bus.o_CMD_Len     = len_q;
  assign bus.o_Pay_Rd_Data = pay_rd_data;
  assign bus.o_Err_Chk     = err_chk_q;
  assign bus.o_Err_Len     = err_len_q;
  assign bus.o_Err_Timeout = err_to_q;
  assign bus.o_Drop        = drop_q;
  assign bus.o_Busy        = busy_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Bench for uart_frame_ctrl: directed scenarios plus randomized frames whose
// expected outcome is derived from how each frame was constructed.
module tb_uart_frame_ctrl;
  localparam int         ML   = 16;
  localparam int         T    = 40;
  localparam logic [7:0] SYNC = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_frame_ctrl_if bus();

  uart_frame_ctrl #(.MAX_LEN(ML), .SYNC_BYTE(SYNC), .TIMEOUT_CLKS(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #50 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Pulse counters sampled mid-cycle; excl counts cycles with >1 event pulse
  int n_chk = 0, n_len = 0, n_to = 0, n_drop = 0, excl = 0;
  always @(negedge clk) begin
    n_chk  <= n_chk  + int'(bus.o_Err_Chk);
    n_len  <= n_len  + int'(bus.o_Err_Len);
    n_to   <= n_to   + int'(bus.o_Err_Timeout);
    n_drop <= n_drop + int'(bus.o_Drop);
    if (int'(bus.o_Err_Chk) + int'(bus.o_Err_Len) + int'(bus.o_Err_Timeout) + int'(bus.o_Drop) > 1)
      excl <= excl + 1;
  end

  logic [7:0] fp [256];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    idle(gap);
    bus.i_RX_DV   = 1'b1;
    bus.i_RX_Byte = b;
    tick();
    bus.i_RX_DV   = 1'b0;
  endtask

  task automatic accept();
    bus.i_CMD_Ready = 1'b1;
    tick();
    bus.i_CMD_Ready = 1'b0;
  endtask

  function automatic int rgap(input bit rnd);
    if (!rnd) return 0;
    return ($urandom_range(0, 9) == 0) ? T - 1 : int'($urandom_range(0, 3));
  endfunction

  function automatic logic [7:0] csum(input logic [7:0] id, input logic [7:0] len);
    int acc = int'(id) + int'(len);
    for (int k = 0; k < int'(len); k++) acc += int'(fp[k]);
    return 8'(acc % 256);
  endfunction

  task automatic send_frame(input logic [7:0] id, input logic [7:0] len,
                            input logic [7:0] chk, input bit rnd);
    send(SYNC, rgap(rnd));
    send(id, rgap(rnd));
    send(len, rgap(rnd));
    for (int k = 0; k < int'(len); k++) send(fp[k], rgap(rnd));
    send(chk, rgap(rnd));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    vectors++;
    if ({bus.o_CMD_Valid, bus.o_CMD_Id, bus.o_CMD_Len, bus.o_Err_Chk, bus.o_Err_Len,
         bus.o_Err_Timeout, bus.o_Drop, bus.o_Busy} !== 22'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%b id=%h len=%h busy=%b required all zero",
               bus.o_CMD_Valid, bus.o_CMD_Id, bus.o_CMD_Len, bus.o_Busy);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (bus.o_Busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy: got %b required 0", bus.o_Busy);
    end
  endtask

  task automatic test_basic();
    fp[0] = 8'h10; fp[1] = 8'h20;
    send_frame(8'h01, 8'h02, 8'h33, 1'b0);
    vectors++;
    if ({bus.o_CMD_Valid, bus.o_Busy, bus.o_CMD_Id, bus.o_CMD_Len} !== {2'b11, 8'h01, 8'h02}) begin
      miscompares++;
      $display("FAIL basic_hold: valid=%b busy=%b id=%h len=%h required 1 1 01 02",
               bus.o_CMD_Valid, bus.o_Busy, bus.o_CMD_Id, bus.o_CMD_Len);
    end
    for (int k = 0; k < 2; k++) begin
      bus.i_Pay_Rd_Addr = 8'(k); #1;
      vectors++;
      if (bus.o_Pay_Rd_Data !== fp[k]) begin
        miscompares++; $display("FAIL basic_buf%0d: got %h required %h", k, bus.o_Pay_Rd_Data, fp[k]);
      end
    end
    bus.i_Pay_Rd_Addr = 8'd20; #1;
    vectors++;
    if (bus.o_Pay_Rd_Data !== 8'h00) begin
      miscompares++; $display("FAIL rd_out_of_range: got %h required 00", bus.o_Pay_Rd_Data);
    end
    bus.i_Pay_Rd_Addr = 8'd0;
    idle(3);
    vectors++;
    if (bus.o_CMD_Valid !== 1'b1) begin
      miscompares++; $display("FAIL basic_still_valid: got %b required 1", bus.o_CMD_Valid);
    end
    accept();
    vectors++;
    if ({bus.o_CMD_Valid, bus.o_Busy} !== 2'b00) begin
      miscompares++; $display("FAIL basic_accept: valid=%b busy=%b required 0 0", bus.o_CMD_Valid, bus.o_Busy);
    end
  endtask

  task automatic test_chk_err();
    int c0 = n_chk;
    fp[0] = 8'h10; fp[1] = 8'h20;
    send_frame(8'h07, 8'h02, 8'h00, 1'b0);
    tick();
    vectors++;
    if (n_chk - c0 !== 1 || bus.o_CMD_Valid !== 1'b0 || bus.o_Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL chk_err: pulses=%0d valid=%b busy=%b required 1 0 0", n_chk - c0, bus.o_CMD_Valid, bus.o_Busy);
    end
    fp[0] = 8'h44;
    send_frame(8'h03, 8'h01, 8'h48, 1'b0);
    vectors++;
    if ({bus.o_CMD_Valid, bus.o_CMD_Id} !== {1'b1, 8'h03}) begin
      miscompares++; $display("FAIL chk_recover: valid=%b id=%h required 1 03", bus.o_CMD_Valid, bus.o_CMD_Id);
    end
    accept();
  endtask

  task automatic test_len_err();
    int c0 = n_len;
    send(SYNC, 0); send(8'h01, 0); send(8'h11, 0);
    tick();
    vectors++;
    if (n_len - c0 !== 1 || bus.o_Busy !== 1'b0 || bus.o_CMD_Valid !== 1'b0) begin
      miscompares++;
      $display("FAIL len_err: pulses=%0d busy=%b valid=%b required 1 0 0", n_len - c0, bus.o_Busy, bus.o_CMD_Valid);
    end
    for (int k = 0; k < ML; k++) fp[k] = 8'(k * 17 + 3);
    send_frame(8'h5C, 8'(ML), csum(8'h5C, 8'(ML)), 1'b0);
    bus.i_Pay_Rd_Addr = 8'(ML - 1); #1;
    vectors++;
    if ({bus.o_CMD_Valid, bus.o_CMD_Len, bus.o_Pay_Rd_Data} !== {1'b1, 8'(ML), fp[ML-1]}) begin
      miscompares++;
      $display("FAIL len_max: valid=%b len=%h last=%h required 1 %h %h",
               bus.o_CMD_Valid, bus.o_CMD_Len, bus.o_Pay_Rd_Data, 8'(ML), fp[ML-1]);
    end
    bus.i_Pay_Rd_Addr = 8'd0;
    accept();
  endtask

  task automatic test_timeout();
    int c0 = n_to;
    send(SYNC, 0); send(8'h01, 0);
    idle(T);
    vectors++;
    if (bus.o_Busy !== 1'b0) begin
      miscompares++; $display("FAIL timeout_hunt: busy=%b required 0", bus.o_Busy);
    end
    idle(2 * T);
    vectors++;
    if (n_to - c0 !== 1) begin
      miscompares++; $display("FAIL timeout_once: pulses=%0d required 1", n_to - c0);
    end
    c0 = n_to;
    fp[0] = 8'hFF;
    send(SYNC, 0); send(8'h01, T - 1);
    vectors++;
    if (bus.o_Busy !== 1'b1) begin
      miscompares++; $display("FAIL tc_busy: busy=%b required 1", bus.o_Busy);
    end
    send(8'h01, T - 1); send(8'hFF, T - 1); send(8'h01, T - 1);
    tick();
    vectors++;
    if (n_to - c0 !== 0 || bus.o_CMD_Valid !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_tc_byte_wins: pulses=%0d valid=%b required 0 1", n_to - c0, bus.o_CMD_Valid);
    end
    accept();
  endtask

  task automatic test_drop();
    int d0 = n_drop;
    fp[0] = 8'h10; fp[1] = 8'h20;
    send_frame(8'h01, 8'h02, 8'h33, 1'b0);
    send(SYNC, 1); send(8'h5A, 1); send(8'h00, 0);
    tick();
    bus.i_Pay_Rd_Addr = 8'd1; #1;
    vectors++;
    if (n_drop - d0 !== 3 || {bus.o_CMD_Valid, bus.o_CMD_Id, bus.o_CMD_Len, bus.o_Pay_Rd_Data} !==
        {1'b1, 8'h01, 8'h02, 8'h20}) begin
      miscompares++;
      $display("FAIL drop_hold: drops=%0d valid=%b id=%h len=%h buf1=%h required 3 1 01 02 20",
               n_drop - d0, bus.o_CMD_Valid, bus.o_CMD_Id, bus.o_CMD_Len, bus.o_Pay_Rd_Data);
    end
    bus.i_Pay_Rd_Addr = 8'd0;
    bus.i_CMD_Ready = 1'b1; bus.i_RX_DV = 1'b1; bus.i_RX_Byte = 8'h77;
    tick();
    bus.i_CMD_Ready = 1'b0; bus.i_RX_DV = 1'b0;
    tick();
    vectors++;
    if (n_drop - d0 !== 4 || bus.o_CMD_Valid !== 1'b0 || bus.o_Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_handshake: drops=%0d valid=%b busy=%b required 4 0 0", n_drop - d0, bus.o_CMD_Valid, bus.o_Busy);
    end
    send(SYNC, 0); send(8'h09, 0); send(8'h00, 0); send(8'h09, 0);
    vectors++;
    if ({bus.o_CMD_Valid, bus.o_CMD_Id, bus.o_CMD_Len} !== {1'b1, 8'h09, 8'h00}) begin
      miscompares++;
      $display("FAIL zero_len: valid=%b id=%h len=%h required 1 09 00", bus.o_CMD_Valid, bus.o_CMD_Id, bus.o_CMD_Len);
    end
    accept();
  endtask

  task automatic test_reset_mid();
    send(SYNC, 0); send(8'h01, 0); send(8'h05, 0); send(8'hAA, 0); send(8'hBB, 0);
    rst = 1'b1;
    tick();
    vectors++;
    if ({bus.o_CMD_Valid, bus.o_CMD_Id, bus.o_CMD_Len, bus.o_Err_Chk, bus.o_Err_Len,
         bus.o_Err_Timeout, bus.o_Drop, bus.o_Busy} !== 22'd0) begin
      miscompares++;
      $display("FAIL reset_mid: valid=%b id=%h len=%h busy=%b required all zero",
               bus.o_CMD_Valid, bus.o_CMD_Id, bus.o_CMD_Len, bus.o_Busy);
    end
    rst = 1'b0;
    fp[0] = 8'hFF;
    send_frame(8'h01, 8'h01, 8'h01, 1'b0);
    vectors++;
    if ({bus.o_CMD_Valid, bus.o_CMD_Id, bus.o_Pay_Rd_Data} !== {1'b1, 8'h01, 8'hFF}) begin
      miscompares++;
      $display("FAIL reset_recover: valid=%b id=%h buf0=%h required 1 01 FF",
               bus.o_CMD_Valid, bus.o_CMD_Id, bus.o_Pay_Rd_Data);
    end
    accept();
  endtask

  task automatic test_random(input int iters);
    for (int it = 0; it < iters; it++) begin
      int kind = int'($urandom_range(0, 4));
      int c_chk = n_chk, c_len = n_len, c_to = n_to, c_drop = n_drop, c_ex = excl;
      int e_chk = 0, e_len = 0, e_to = 0, e_drop = 0;
      logic [7:0] id  = 8'($urandom);
      logic [7:0] len = 8'($urandom_range(0, ML));
      if ($urandom_range(0, 4) == 0) len = 8'(ML);
      if (kind == 2) len = 8'($urandom_range(ML + 1, 255));
      for (int k = 0; k < 256; k++) fp[k] = 8'($urandom);
      if (kind == 4) begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
          logic [7:0] b = 8'($urandom);
          if (b == SYNC) b = 8'h00;
          send(b, rgap(1'b1));
        end
      end
      case (kind)
        0, 4: begin
          int nd = int'($urandom_range(0, 2));
          send_frame(id, len, csum(id, len), 1'b1);
          vectors++;
          if ({bus.o_CMD_Valid, bus.o_CMD_Id, bus.o_CMD_Len} !== {1'b1, id, len}) begin
            miscompares++;
            $display("FAIL rnd_frame[%0d]: valid=%b id=%h len=%h required 1 %h %h",
                     it, bus.o_CMD_Valid, bus.o_CMD_Id, bus.o_CMD_Len, id, len);
          end
          for (int k = 0; k < int'(len); k++) begin
            bus.i_Pay_Rd_Addr = 8'(k); #1;
            vectors++;
            if (bus.o_Pay_Rd_Data !== fp[k]) begin
              miscompares++;
              $display("FAIL rnd_buf[%0d][%0d]: got %h required %h", it, k, bus.o_Pay_Rd_Data, fp[k]);
            end
          end
          bus.i_Pay_Rd_Addr = 8'd0;
          for (int d = 0; d < nd; d++) send(8'($urandom), rgap(1'b1));
          e_drop = nd;
          idle(int'($urandom_range(0, 2)));
          accept();
          vectors++;
          if (bus.o_CMD_Valid !== 1'b0) begin
            miscompares++; $display("FAIL rnd_accept[%0d]: valid=%b required 0", it, bus.o_CMD_Valid);
          end
        end
        1: begin
          send_frame(id, len, csum(id, len) + 8'($urandom_range(1, 255)), 1'b1);
          e_chk = 1;
        end
        2: begin
          send(SYNC, rgap(1'b1)); send(id, rgap(1'b1)); send(len, rgap(1'b1));
          e_len = 1;
        end
        default: begin
          int m = int'($urandom_range(0, 2));
          send(SYNC, rgap(1'b1)); send(id, rgap(1'b1));
          if (m >= 1) send(len, rgap(1'b1));
          if (m == 2 && len > 0)
            for (int k = 0; k < int'($urandom_range(0, int'(len) - 1)); k++) send(fp[k], rgap(1'b1));
          idle(T);
          e_to = 1;
        end
      endcase
      tick();
      vectors++;
      if (n_chk - c_chk !== e_chk || n_len - c_len !== e_len || n_to - c_to !== e_to ||
          n_drop - c_drop !== e_drop || excl - c_ex !== 0 || bus.o_Busy !== 1'b0) begin
        miscompares++;
        $display("FAIL rnd_events[%0d] kind=%0d: chk=%0d len=%0d to=%0d drop=%0d excl=%0d busy=%b required %0d %0d %0d %0d 0 0",
                 it, kind, n_chk - c_chk, n_len - c_len, n_to - c_to, n_drop - c_drop,
                 excl - c_ex, bus.o_Busy, e_chk, e_len, e_to, e_drop);
      end
    end
  endtask

  initial begin
    bus.i_RX_DV       = 1'b0;
    bus.i_RX_Byte     = 8'h00;
    bus.i_CMD_Ready   = 1'b0;
    bus.i_Pay_Rd_Addr = 8'h00;
    test_reset();
    test_basic();
    test_chk_err();
    test_len_err();
    test_timeout();
    test_drop();
    test_reset_mid();
    test_random(40);
    vectors++;
    if (excl !== 0) begin
      miscompares++; $display("FAIL pulse_exclusive: overlapping cycles=%0d required 0", excl);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_frame_ctrl.md
Name: uart_frame_ctrl

Overview:
- Sequences the byte stream from the UART receiver into framed commands.
- Hunts for a sync byte, then captures ID, length, payload and checksum, and validates the frame.
- Presents each good frame to downstream logic through a valid/ready handshake and a payload read port.
- Sits between the UART receiver (byte + data-valid pulse) and the command decoder.

Parameters:
- MAX_LEN, 16, maximum payload bytes per frame (1..255).
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CLKS, 8680, idle clocks allowed between bytes inside a frame. Default is about 4 byte times at 217 clocks/bit.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_RX_DV  in  1  one-cycle byte-valid pulse from UART receiver
- i_RX_Byte  in  8  received byte, qualified by i_RX_DV
- o_CMD_Valid  out  1  good frame available
- i_CMD_Ready  in  1  downstream accepts frame
- o_CMD_Id  out  8  frame ID byte
- o_CMD_Len  out  8  payload length
- i_Pay_Rd_Addr  in  8  payload read index
- o_Pay_Rd_Data  out  8  payload byte at index (combinational)
- o_Err_Chk  out  1  one-cycle pulse: checksum mismatch
- o_Err_Len  out  1  one-cycle pulse: LEN > MAX_LEN
- o_Err_Timeout  out  1  one-cycle pulse: inter-byte timeout
- o_Drop  out  1  one-cycle pulse: byte discarded while holding a frame
- o_Busy  out  1  high in any state other than HUNT

Behaviour:
- Reset (rst=1 at a clk edge), also when asserted mid-frame:
  - state goes to HUNT.
  - All outputs go to 0: o_CMD_Valid, o_CMD_Id, o_CMD_Len, all error pulses, o_Drop, o_Busy.
  - Timeout counter and payload index clear.
  - Payload buffer contents are don't-care.
- Checksum rule: CHK = 8-bit sum, modulo 256, of ID, LEN and all payload bytes. SYNC is excluded.
- States and transitions. Each transition fires on a cycle with i_RX_DV=1 unless stated otherwise.
  - HUNT: byte==SYNC_BYTE -> GET_ID. Any other byte is ignored silently.
  - GET_ID: store ID, seed sum=ID -> GET_LEN.
  - GET_LEN:
    - LEN > MAX_LEN -> pulse o_Err_Len, go to HUNT.
    - LEN == 0 -> GET_CHK.
    - Otherwise -> GET_PAY.
    - Store LEN and add it to the sum in all cases.
  - GET_PAY: write the byte to buffer[idx], add it to the sum, idx++. When the last byte (idx==LEN-1) is written -> GET_CHK.
  - GET_CHK:
    - byte==sum -> HOLD.
    - Otherwise -> pulse o_Err_Chk, go to HUNT.
  - HOLD: o_CMD_Valid=1. On a cycle with o_CMD_Valid and i_CMD_Ready both high -> HUNT; o_CMD_Valid is low the next cycle.
- Latency: o_CMD_Valid rises on the cycle after the checksum byte's i_RX_DV.
  - o_CMD_Id, o_CMD_Len and the buffer stay stable for the whole time valid is high.
- i_CMD_Ready is ignored when o_CMD_Valid=0.
- Any i_RX_DV in HOLD (including the handshake cycle) discards the byte and pulses o_Drop. A SYNC byte in HOLD is not recognised.
- Timeout:
  - The counter runs only in GET_ID, GET_LEN, GET_PAY and GET_CHK.
  - It clears on every i_RX_DV and on every state entry.
  - When it reaches TIMEOUT_CLKS-1 with no byte that cycle -> pulse o_Err_Timeout, go to HUNT.
  - A byte arriving on the terminal-count cycle wins: it is processed normally and no timeout is flagged.
- At most one of the error pulses or o_Drop is asserted per cycle. Each is exactly 1 cycle wide, registered.
- Payload read port:
  - o_Pay_Rd_Data = buffer[i_Pay_Rd_Addr] when i_Pay_Rd_Addr < MAX_LEN, else 8'h00.
  - Entries at or above LEN are don't-care.
- Widths: sum and idx wrap modulo 256; the timeout counter is sized to $clog2(TIMEOUT_CLKS).

Test Plan:
- Bytes A5 01 02 10 20 33, no ready -> o_CMD_Valid=1 one cycle after the 33 byte, Id=01, Len=02, buffer[0]=10, buffer[1]=20, buffer[2] read -> don't-care. Then ready=1 -> valid=0 next cycle.
- Bytes A5 07 02 10 20 00 -> o_Err_Chk pulses once, valid stays 0. A following good frame is accepted.
- Bytes A5 01 11 (MAX_LEN=16) -> o_Err_Len pulses after the 11 byte, state HUNT, o_Busy=0.
- Bytes A5 01 then silence for TIMEOUT_CLKS clocks -> o_Err_Timeout pulses exactly once. A byte landing exactly on the terminal-count cycle -> no timeout.
- Good frame held (ready=0), then 3 more bytes -> o_Drop pulses 3 times, Id/Len/buffer unchanged. Zero-length frame A5 09 00 09 -> valid with Len=0.
- rst=1 asserted mid-payload -> all outputs 0 next cycle. A subsequent frame A5 01 01 FF 01 -> valid, Id=01, buffer[0]=FF.
